// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus bundle: redirect inputs, instruction-memory port and
// the F/D output slot, seen from the sequencer (master) and its environment.
interface fetch_sequencer_if;
    logic        stall;
    logic        int_req;
    logic        eret_valid;
    logic [31:0] epc;
    logic        br_valid;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        f_valid;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic [4:0]  f_excode;

    modport master (
        input  stall, int_req, eret_valid, epc, br_valid, br_target,
        input  imem_ack, imem_rdata,
        output imem_req, imem_addr,
        output f_valid, f_instr, f_pc, f_excode
    );

    modport slave (
        output stall, int_req, eret_valid, epc, br_valid, br_target,
        output imem_ack, imem_rdata,
        input  imem_req, imem_addr,
        input  f_valid, f_instr, f_pc, f_excode
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues one fetch at a time, applies
// prioritised redirects and buffers one instruction for decode.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI    = 32'h0000_6ffc,
    parameter logic [4:0]  EXC_ADEL   = 5'h4
) (
    input logic               clk,
    input logic               reset,
    fetch_sequencer_if.master bus
);
    typedef enum logic [1:0] {RST_WAIT, ISSUE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        f_valid_q, f_valid_d;
    logic [31:0] f_instr_q, f_instr_d;
    logic [31:0] f_pc_q, f_pc_d;
    logic [4:0]  f_excode_q, f_excode_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        redir;
    logic [31:0] target;
    logic        legal;
    logic        slot_free;

    always_comb begin
        redir = bus.int_req | bus.eret_valid | bus.br_valid;
        if (bus.int_req)
            target = HANDLER_PC;
        else if (bus.eret_valid)
            target = bus.epc;
        else
            target = bus.br_target;
        legal = (pc_q[1:0] == 2'b00) && (pc_q >= TEXT_LO) && (pc_q <= TEXT_HI);
        slot_free = !f_valid_q || !bus.stall;
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        f_valid_d     = f_valid_q && bus.stall;
        f_instr_d     = f_instr_q;
        f_pc_d        = f_pc_q;
        f_excode_d    = f_excode_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;

        unique case (state_q)
            RST_WAIT: state_d = ISSUE;
            ISSUE: begin
                if (redir) begin
                    pc_d = target;
                end else if (slot_free && legal) begin
                    state_d = BUSY;
                end else if (slot_free) begin
                    f_valid_d  = 1'b1;
                    f_instr_d  = 32'h0;
                    f_pc_d     = pc_q;
                    f_excode_d = EXC_ADEL;
                    pc_d       = pc_q + 32'd4;
                end
            end
            BUSY: begin
                if (bus.imem_ack) begin
                    state_d      = ISSUE;
                    pend_valid_d = 1'b0;
                    if (redir || pend_valid_q) begin
                        pc_d = redir ? target : pend_target_q;
                    end else begin
                        f_valid_d  = 1'b1;
                        f_instr_d  = bus.imem_rdata;
                        f_pc_d     = pc_q;
                        f_excode_d = 5'h0;
                        pc_d       = pc_q + 32'd4;
                    end
                end else if (redir) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = target;
                end
            end
            default: state_d = RST_WAIT;
        endcase

        // Branches keep the slot: it holds the delay-slot instruction.
        if (bus.int_req || bus.eret_valid)
            f_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RST_WAIT;
            pc_q          <= RESET_PC;
            f_valid_q     <= 1'b0;
            f_instr_q     <= 32'h0;
            f_pc_q        <= 32'h0;
            f_excode_q    <= 5'h0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            f_valid_q     <= f_valid_d;
            f_instr_q     <= f_instr_d;
            f_pc_q        <= f_pc_d;
            f_excode_q    <= f_excode_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign bus.imem_req  = (state_q == BUSY);
    assign bus.imem_addr = pc_q;
    assign bus.f_valid   = f_valid_q;
    assign bus.f_instr   = f_instr_q;
    assign bus.f_pc      = f_pc_q;
    assign bus.f_excode  = f_excode_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a memory model answers fetches and a
// scoreboard checks every instruction decode consumes from the slot.
module tb_fetch_sequencer;
    logic clk;
    logic reset;
    fetch_sequencer_if bus();

    fetch_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } slot_t;

    slot_t sb_q[$];
    int    vectors = 0;
    int    errors  = 0;
    int    mem_wait = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr,
                        input logic [4:0] exc);
        slot_t s;
        s.pc = pc;
        s.instr = instr;
        s.exc = exc;
        sb_q.push_back(s);
    endtask

    // Memory model: ack after mem_wait idle cycles, data = 0xA000_0000+addr.
    initial begin
        int cnt;
        cnt = 0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (reset || !bus.imem_req) begin
                bus.imem_ack = 1'b0;
                cnt = 0;
            end else if (cnt == mem_wait) begin
                bus.imem_ack = 1'b1;
                bus.imem_rdata = 32'hA000_0000 + bus.imem_addr;
                cnt = 0;
            end else begin
                bus.imem_ack = 1'b0;
                cnt++;
            end
        end
    end

    // Monitor: decode consumes the slot on f_valid & !stall.
    initial begin
        slot_t got, exp;
        forever begin
            @(negedge clk);
            if (!reset && bus.f_valid && !bus.stall) begin
                got.pc = bus.f_pc;
                got.instr = bus.f_instr;
                got.exc = bus.f_excode;
                vectors++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL slot: unexpected pc=%h instr=%h exc=%h",
                             got.pc, got.instr, got.exc);
                end else begin
                    exp = sb_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL slot: got pc=%h instr=%h exc=%h, expected pc=%h instr=%h exc=%h",
                                 got.pc, got.instr, got.exc,
                                 exp.pc, exp.instr, exp.exc);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.int_req = 1'b0;
        bus.eret_valid = 1'b0;
        bus.epc = 32'h0;
        bus.br_valid = 1'b0;
        bus.br_target = 32'h0;
        tick();
        check("rst_req", {31'h0, bus.imem_req}, 32'h0);
        check("rst_addr", bus.imem_addr, 32'h3000);
        check("rst_fvalid", {31'h0, bus.f_valid}, 32'h0);
        check("rst_finstr", bus.f_instr, 32'h0);
        check("rst_fpc", bus.f_pc, 32'h0);
        check("rst_fexc", {27'h0, bus.f_excode}, 32'h0);
        tick();
        reset = 1'b0;
        push(32'h3000, 32'hA000_3000, 5'h0);
        push(32'h3004, 32'hA000_3004, 5'h0);
        tick();
        check("e1_req", {31'h0, bus.imem_req}, 32'h0);
        tick();
        check("e2_req", {31'h0, bus.imem_req}, 32'h1);
        check("e2_addr", bus.imem_addr, 32'h3000);
        tick();
        check("e3_fvalid", {31'h0, bus.f_valid}, 32'h1);
        check("e3_fpc", bus.f_pc, 32'h3000);
        tick();
        check("e4_addr", bus.imem_addr, 32'h3004);
        tick();
        check("e5_fpc", bus.f_pc, 32'h3004);
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_fpc", bus.f_pc, 32'h3004);
            check("stall_req", {31'h0, bus.imem_req}, 32'h0);
        end
        bus.stall = 1'b0;
        tick();
        check("unstall_req", {31'h0, bus.imem_req}, 32'h1);
        check("unstall_addr", bus.imem_addr, 32'h3008);
        tick();
        bus.stall = 1'b1;
        tick();
        check("hold_fvalid", {31'h0, bus.f_valid}, 32'h1);
        bus.int_req = 1'b1;
        bus.eret_valid = 1'b1;
        bus.epc = 32'h5000;
        bus.br_valid = 1'b1;
        bus.br_target = 32'h3100;
        tick();
        check("prio_flush", {31'h0, bus.f_valid}, 32'h0);
        check("prio_pc", bus.imem_addr, 32'h4180);
        bus.int_req = 1'b0;
        bus.eret_valid = 1'b0;
        bus.br_valid = 1'b0;
        bus.stall = 1'b0;
        mem_wait = 3;
        tick();
        check("e15_addr", bus.imem_addr, 32'h4180);
        tick();
        bus.br_valid = 1'b1;
        bus.br_target = 32'h3100;
        tick();
        bus.br_valid = 1'b0;
        check("busy_hold_req", {31'h0, bus.imem_req}, 32'h1);
        check("busy_hold_addr", bus.imem_addr, 32'h4180);
        tick();
        check("busy_wait_req", {31'h0, bus.imem_req}, 32'h1);
        tick();
        check("drop_req", {31'h0, bus.imem_req}, 32'h0);
        check("drop_fvalid", {31'h0, bus.f_valid}, 32'h0);
        mem_wait = 0;
        push(32'h3100, 32'hA000_3100, 5'h0);
        tick();
        check("pend_req", {31'h0, bus.imem_req}, 32'h1);
        check("pend_addr", bus.imem_addr, 32'h3100);
        tick();
        check("e21_fpc", bus.f_pc, 32'h3100);
        bus.br_valid = 1'b1;
        bus.br_target = 32'h3002;
        push(32'h3002, 32'h0, 5'h4);
        push(32'h3006, 32'h0, 5'h4);
        tick();
        bus.br_valid = 1'b0;
        check("e22_req", {31'h0, bus.imem_req}, 32'h0);
        tick();
        check("mis_req", {31'h0, bus.imem_req}, 32'h0);
        check("mis_exc", {27'h0, bus.f_excode}, 32'h4);
        tick();
        check("mis2_req", {31'h0, bus.imem_req}, 32'h0);
        check("mis2_fpc", bus.f_pc, 32'h3006);
        bus.eret_valid = 1'b1;
        bus.epc = 32'h6ffc;
        tick();
        bus.eret_valid = 1'b0;
        check("eret_flush", {31'h0, bus.f_valid}, 32'h0);
        push(32'h6ffc, 32'hA000_6ffc, 5'h0);
        push(32'h7000, 32'h0, 5'h4);
        tick();
        check("top_req", {31'h0, bus.imem_req}, 32'h1);
        check("top_addr", bus.imem_addr, 32'h6ffc);
        tick();
        check("top_fpc", bus.f_pc, 32'h6ffc);
        tick();
        check("over_req", {31'h0, bus.imem_req}, 32'h0);
        check("over_fpc", bus.f_pc, 32'h7000);
        check("over_exc", {27'h0, bus.f_excode}, 32'h4);
        bus.int_req = 1'b1;
        tick();
        bus.int_req = 1'b0;
        check("int_flush", {31'h0, bus.f_valid}, 32'h0);
        push(32'h4180, 32'hA000_4180, 5'h0);
        tick();
        check("int_req", {31'h0, bus.imem_req}, 32'h1);
        check("int_addr", bus.imem_addr, 32'h4180);
        tick();
        check("int_fpc", bus.f_pc, 32'h4180);
        mem_wait = 5;
        tick();
        check("mid_req", {31'h0, bus.imem_req}, 32'h1);
        check("mid_addr", bus.imem_addr, 32'h4184);
        #3;
        reset = 1'b1;
        #1;
        check("arst_req", {31'h0, bus.imem_req}, 32'h0);
        check("arst_fvalid", {31'h0, bus.f_valid}, 32'h0);
        check("arst_addr", bus.imem_addr, 32'h3000);
        tick();
        tick();
        check("sb_empty", sb_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
